dpd_tone_sequencer: RTL

Programmable tone scheduler that drives one dds_signal_generator instance in the DPD test bench/signal path. It walks a small table of (frequency, amplitude, dwell) entries. Each tone is ramped up, held, then ramped down. Frequency changes only while amplitude is zero, so the DDS output has no step discontinuities. The block produces the DDS start, frequency and amplitude controls, plus sequencing status for the bench and the DPD capture logic.

---
 rtl/dpd_tone_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dpd_tone_sequencer.sv
// Tone scheduler for the DPD DDS: plays (freq, ampl, dwell) table entries as
// ramp-up / hold / ramp-down bursts, retuning only while the amplitude is zero.
module dpd_tone_sequencer #(
  parameter int N_STEPS = 8,
  parameter int W_FREQ  = 32,
  parameter int W_AMPL  = 16,
  parameter int W_DWELL = 24,
  parameter int AMP_INC = 64,
  localparam int AW     = $clog2(N_STEPS)
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [W_FREQ-1:0]  cfg_freq,
  input  logic [W_AMPL-1:0]  cfg_ampl,
  input  logic [W_DWELL-1:0] cfg_dwell,
  input  logic [AW:0]        n_active,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic               dds_start,
  output logic [W_FREQ-1:0]  dds_freq,
  output logic [W_AMPL-1:0]  dds_ampl,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               step_done,
  output logic               seq_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RAMP_UP,
    S_HOLD,
    S_RAMP_DOWN,
    S_NEXT
  } state_t;

  localparam logic [W_AMPL:0]  INC_W  = (W_AMPL+1)'(AMP_INC);
  localparam logic [AW:0]      N_MAX  = (AW+1)'(N_STEPS);
  localparam logic [W_DWELL-1:0] DWELL_ONE = W_DWELL'(1);

  state_t state, state_nxt;

  logic [W_FREQ-1:0]  freq_tbl  [N_STEPS];
  logic [W_AMPL-1:0]  ampl_tbl  [N_STEPS];
  logic [W_DWELL-1:0] dwell_tbl [N_STEPS];

  logic [AW-1:0]      idx;
  logic [AW:0]        n_act;
  logic [W_AMPL-1:0]  tgt;
  logic [W_DWELL-1:0] dwell_cnt;
  logic               abort_f;

  logic [W_AMPL-1:0]  up_val;
  logic [W_AMPL-1:0]  dn_val;
  logic               start_ok;
  logic               is_last;

  // Sum is formed one bit wider so a near-full-scale target can never wrap.
  function automatic logic [W_AMPL-1:0] ramp_up_sat(input logic [W_AMPL-1:0] cur,
                                                    input logic [W_AMPL-1:0] lim);
    logic [W_AMPL:0] sum;
    sum = {1'b0, cur} + INC_W;
    return (sum >= {1'b0, lim}) ? lim : sum[W_AMPL-1:0];
  endfunction

  function automatic logic [W_AMPL-1:0] ramp_dn_sat(input logic [W_AMPL-1:0] cur);
    return ({1'b0, cur} <= INC_W) ? '0 : (cur - INC_W[W_AMPL-1:0]);
  endfunction

  assign up_val   = ramp_up_sat(dds_ampl, tgt);
  assign dn_val   = ramp_dn_sat(dds_ampl);
  assign start_ok = start && !stop && (n_active != '0) && (n_active <= N_MAX);
  assign is_last  = ({1'b0, idx} == (n_act - 1'b1));
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_ok) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = stop ? S_RAMP_DOWN : S_RAMP_UP;
      S_RAMP_UP: begin
        if (stop)               state_nxt = S_RAMP_DOWN;
        else if (up_val == tgt) state_nxt = S_HOLD;
      end
      S_HOLD:      if (stop || dwell_cnt <= DWELL_ONE) state_nxt = S_RAMP_DOWN;
      S_RAMP_DOWN: if (dn_val == '0) state_nxt = S_NEXT;
      S_NEXT: begin
        if (abort_f || stop)       state_nxt = S_IDLE;
        else if (is_last && !loop_en) state_nxt = S_IDLE;
        else                       state_nxt = S_LOAD;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < N_STEPS; i++) begin
        freq_tbl[i]  <= '0;
        ampl_tbl[i]  <= '0;
        dwell_tbl[i] <= '0;
      end
    end else if (cfg_we) begin
      freq_tbl[cfg_addr]  <= cfg_freq;
      ampl_tbl[cfg_addr]  <= cfg_ampl;
      dwell_tbl[cfg_addr] <= cfg_dwell;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dds_start <= 1'b0;
      dds_freq  <= '0;
      dds_ampl  <= '0;
      step_idx  <= '0;
      step_done <= 1'b0;
      seq_done  <= 1'b0;
      idx       <= '0;
      n_act     <= '0;
      tgt       <= '0;
      dwell_cnt <= '0;
      abort_f   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      seq_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          dds_start <= 1'b0;
          dds_ampl  <= '0;
          if (start_ok) begin
            n_act <= n_active;
            idx   <= '0;
          end
        end
        // Working registers are captured here only, so table writes to the
        // playing entry wait until that entry is loaded again.
        S_LOAD: begin
          dds_freq  <= freq_tbl[idx];
          tgt       <= ampl_tbl[idx];
          dwell_cnt <= (dwell_tbl[idx] == '0) ? DWELL_ONE : dwell_tbl[idx];
          dds_ampl  <= '0;
          dds_start <= 1'b1;
          step_idx  <= idx;
          if (stop) abort_f <= 1'b1;
        end
        S_RAMP_UP: begin
          if (stop) abort_f  <= 1'b1;
          else      dds_ampl <= up_val;
        end
        S_HOLD: begin
          if (stop) abort_f <= 1'b1;
          else if (dwell_cnt > DWELL_ONE) dwell_cnt <= dwell_cnt - DWELL_ONE;
        end
        S_RAMP_DOWN: begin
          dds_ampl <= dn_val;
          if (stop) abort_f <= 1'b1;
        end
        S_NEXT: begin
          if (abort_f || stop) begin
            abort_f   <= 1'b0;
            dds_start <= 1'b0;
          end else begin
            step_done <= 1'b1;
            if (is_last) begin
              if (loop_en) begin
                idx <= '0;
              end else begin
                seq_done  <= 1'b1;
                dds_start <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
